// File: rtl/pipelined_comparator.sv
// pipelined_comparator: compares two WIDTH-bit operands one CHUNK-bit slice per
// stage, most significant slice first, and carries the running EQ/GT state down
// the pipeline. It supports signed and unsigned ordering, a valid/ready handshake
// with whole-pipeline stall, and a sideband tag that travels with each compare.
// Optional macro PIPELINED_COMPARATOR_FLUSH_EN adds a 'flush' input. Flush drops
// every in-flight request, for example results from a mispredicted path.
module pipelined_comparator #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  parameter int TAG_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_signed,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_eq,
  output logic             out_gt,
  output logic             out_lt,
  output logic [TAG_W-1:0] out_tag
`ifdef PIPELINED_COMPARATOR_FLUSH_EN
  ,
  input  logic             flush
`endif
);

  localparam int STAGES = WIDTH / CHUNK;

  // Flipping the sign bit of both operands maps two's-complement order onto
  // unsigned order, so every stage below can use plain unsigned slice compares.
  localparam logic [WIDTH-1:0] SIGN_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  logic w_advance;
  logic w_flush;
  logic w_accept;

  logic             r_valid [STAGES];
  logic             r_eq    [STAGES];
  logic             r_gt    [STAGES];
  logic [TAG_W-1:0] r_tag   [STAGES];

`ifdef PIPELINED_COMPARATOR_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  // The whole pipeline moves together. It stalls only when a finished result
  // is waiting and the consumer is not taking it.
  assign w_advance = !r_valid[STAGES-1] || out_ready;
  assign in_ready  = w_advance && !w_flush;
  assign w_accept  = in_valid && in_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Operand bits still to be compared when a request enters stage k.
    localparam int OPW = WIDTH - k * CHUNK;

    logic [OPW-1:0]   w_a;
    logic [OPW-1:0]   w_b;
    logic             w_validIn;
    logic             w_eqIn;
    logic             w_gtIn;
    logic [TAG_W-1:0] w_tagIn;
    logic [CHUNK-1:0] w_sliceA;
    logic [CHUNK-1:0] w_sliceB;
    logic             w_eq;
    logic             w_gt;

    if (k == 0) begin : g_head
      assign w_a       = in_signed ? (in_a ^ SIGN_MASK) : in_a;
      assign w_b       = in_signed ? (in_b ^ SIGN_MASK) : in_b;
      assign w_validIn = w_accept;
      assign w_eqIn    = 1'b1;
      assign w_gtIn    = 1'b0;
      assign w_tagIn   = in_tag;
    end else begin : g_body
      assign w_a       = g_stage[k-1].g_carry.r_a;
      assign w_b       = g_stage[k-1].g_carry.r_b;
      assign w_validIn = r_valid[k-1];
      assign w_eqIn    = r_eq[k-1];
      assign w_gtIn    = r_gt[k-1];
      assign w_tagIn   = r_tag[k-1];
    end

    assign w_sliceA = w_a[OPW-1 -: CHUNK];
    assign w_sliceB = w_b[OPW-1 -: CHUNK];
    assign w_eq     = w_eqIn && (w_sliceA == w_sliceB);
    assign w_gt     = w_gtIn || (w_eqIn && (w_sliceA > w_sliceB));

    // Stage state: the valid bit is cleared by reset or flush; otherwise it moves with the pipeline.
    always_ff @(posedge clock) begin
      if (reset) begin
        r_valid[k] <= 1'b0;
        r_eq[k]    <= 1'b0;
        r_gt[k]    <= 1'b0;
        r_tag[k]   <= '0;
      end else if (w_flush) begin
        r_valid[k] <= 1'b0;
      end else if (w_advance) begin
        r_valid[k] <= w_validIn;
        r_eq[k]    <= w_eq;
        r_gt[k]    <= w_gt;
        r_tag[k]   <= w_tagIn;
      end
    end

    // Only the slices that later stages still need are carried forward.
    if (k < STAGES - 1) begin : g_carry
      logic [OPW-CHUNK-1:0] r_a;
      logic [OPW-CHUNK-1:0] r_b;

      // Remaining operand bits move with the pipeline; they carry no reset because valid qualifies them.
      always_ff @(posedge clock) begin
        if (w_advance) begin
          r_a <= w_a[OPW-CHUNK-1:0];
          r_b <= w_b[OPW-CHUNK-1:0];
        end
      end
    end
  end

  assign out_valid = r_valid[STAGES-1];
  assign out_eq    = r_eq[STAGES-1];
  assign out_gt    = r_gt[STAGES-1];
  assign out_lt    = r_valid[STAGES-1] && !r_eq[STAGES-1] && !r_gt[STAGES-1];
  assign out_tag   = r_tag[STAGES-1];

endmodule

// File: tb/tb_pipelined_comparator.sv
// tb_pipelined_comparator: directed bench for pipelined_comparator. It drives a
// 32/8 instance and a 16/4 instance. Build with PIPELINED_COMPARATOR_FLUSH_EN
// defined to include the flush scenario.
module tb_pipelined_comparator;

  logic        clock = 1'b0;
  logic        reset;

  logic        inValid, inReady, inSigned, outValid, outReady;
  logic        outEq, outGt, outLt;
  logic [31:0] inA, inB;
  logic [4:0]  inTag, outTag;

  logic        inValid16, inReady16, inSigned16, outValid16, outReady16;
  logic        outEq16, outGt16, outLt16;
  logic [15:0] inA16, inB16;
  logic [4:0]  inTag16, outTag16;

`ifdef PIPELINED_COMPARATOR_FLUSH_EN
  logic        flush;
  logic        flush16;
`endif

  int testsRun    = 0;
  int testsFailed = 0;

  // Free-running clock, period 10.
  always #5 clock = ~clock;

  pipelined_comparator #(.WIDTH(32), .CHUNK(8), .TAG_W(5)) dut (
    .clock(clock), .reset(reset),
    .in_valid(inValid), .in_ready(inReady), .in_a(inA), .in_b(inB),
    .in_signed(inSigned), .in_tag(inTag),
    .out_valid(outValid), .out_ready(outReady),
    .out_eq(outEq), .out_gt(outGt), .out_lt(outLt), .out_tag(outTag)
`ifdef PIPELINED_COMPARATOR_FLUSH_EN
    , .flush(flush)
`endif
  );

  pipelined_comparator #(.WIDTH(16), .CHUNK(4), .TAG_W(5)) dut16 (
    .clock(clock), .reset(reset),
    .in_valid(inValid16), .in_ready(inReady16), .in_a(inA16), .in_b(inB16),
    .in_signed(inSigned16), .in_tag(inTag16),
    .out_valid(outValid16), .out_ready(outReady16),
    .out_eq(outEq16), .out_gt(outGt16), .out_lt(outLt16), .out_tag(outTag16)
`ifdef PIPELINED_COMPARATOR_FLUSH_EN
    , .flush(flush16)
`endif
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue one request to the 32-bit instance, then wait for its result.
  // lat counts edges from the accept edge (inclusive) to out_valid; -1 on timeout.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic s, input logic [4:0] tag,
                               output int lat, output logic [2:0] flags,
                               output logic [4:0] tagOut);
    inA = a; inB = b; inSigned = s; inTag = tag; inValid = 1'b1;
    tick();
    inValid = 1'b0;
    lat = 1;
    while (outValid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    if (outValid !== 1'b1) lat = -1;
    flags  = {outEq, outGt, outLt};
    tagOut = outTag;
  endtask

  task automatic test_reset();
    reset = 1'b1; inValid = 1'b0; outReady = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    testsRun++; if (outValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_out_valid got %b want 0", outValid); end
    testsRun++; if ({outEq, outGt, outLt} !== 3'b000) begin testsFailed++; $display("[TB] FAIL reset_flags got %b want 000", {outEq, outGt, outLt}); end
    testsRun++; if (outTag !== 5'd0) begin testsFailed++; $display("[TB] FAIL reset_tag got %0d want 0", outTag); end
    testsRun++; if (inReady !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_in_ready got %b want 1", inReady); end
    testsRun++; if (outValid16 !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset16_out_valid got %b want 0", outValid16); end
  endtask

  task automatic test_unsigned();
    int lat; logic [2:0] fl; logic [4:0] tg;
    outReady = 1'b1;
    applyStimulus(32'h0000_0010, 32'h0000_000F, 1'b0, 5'd3, lat, fl, tg);
    testsRun++; if (lat != 4) begin testsFailed++; $display("[TB] FAIL unsigned_latency got %0d want 4", lat); end
    testsRun++; if (fl !== 3'b010) begin testsFailed++; $display("[TB] FAIL unsigned_flags eq/gt/lt got %b want 010", fl); end
    testsRun++; if (tg !== 5'd3) begin testsFailed++; $display("[TB] FAIL unsigned_tag got %0d want 3", tg); end
  endtask

  task automatic test_signed();
    logic [31:0] va [7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000,
                            32'h8000_0000, 32'h8000_0000, 32'h1234_5678};
    logic [31:0] vb [7] = '{32'h0000_0001, 32'h0000_0001, 32'h8000_0000, 32'h8000_0000,
                            32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h1234_5679};
    logic        vs [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [2:0]  ve [7] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b001, 3'b010, 3'b001};
    int lat; logic [2:0] fl; logic [4:0] tg;
    outReady = 1'b1;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(va[i], vb[i], vs[i], 5'(i + 4), lat, fl, tg);
      testsRun++; if (lat != 4) begin testsFailed++; $display("[TB] FAIL signed_latency[%0d] got %0d want 4", i, lat); end
      testsRun++; if (fl !== ve[i]) begin testsFailed++; $display("[TB] FAIL signed_flags[%0d] eq/gt/lt got %b want %b", i, fl, ve[i]); end
      testsRun++; if (tg !== 5'(i + 4)) begin testsFailed++; $display("[TB] FAIL signed_tag[%0d] got %0d want %0d", i, tg, i + 4); end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] expFl;
    int received = 0;
    outReady = 1'b1;
    for (int c = 0; c < 13; c++) begin
      inValid = (c < 8); inA = 32'(c); inB = 32'd3; inSigned = 1'b0; inTag = 5'(c);
      tick();
      testsRun++; if (outValid !== ((c >= 3 && c <= 10) ? 1'b1 : 1'b0)) begin testsFailed++; $display("[TB] FAIL b2b_valid cycle %0d got %b", c, outValid); end
      if (c >= 3 && c <= 10 && outValid === 1'b1) begin
        received++;
        expFl = (c - 3 < 3) ? 3'b001 : ((c - 3 == 3) ? 3'b100 : 3'b010);
        testsRun++; if (outTag !== 5'(c - 3)) begin testsFailed++; $display("[TB] FAIL b2b_tag cycle %0d got %0d want %0d", c, outTag, c - 3); end
        testsRun++; if ({outEq, outGt, outLt} !== expFl) begin testsFailed++; $display("[TB] FAIL b2b_flags cycle %0d got %b want %b", c, {outEq, outGt, outLt}, expFl); end
      end
    end
    inValid = 1'b0;
    testsRun++; if (received != 8) begin testsFailed++; $display("[TB] FAIL b2b_count got %0d want 8", received); end
  endtask

  task automatic test_backpressure();
    logic [31:0] va [4] = '{32'd100, 32'd5, 32'd7, 32'hFFFF_FFFF};
    logic [31:0] vb [4] = '{32'd100, 32'd6, 32'd3, 32'd0};
    logic        vs [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [2:0]  ve [4] = '{3'b100, 3'b001, 3'b010, 3'b001};
    outReady = 1'b0;
    for (int c = 0; c < 4; c++) begin
      inValid = 1'b1; inA = va[c]; inB = vb[c]; inSigned = vs[c]; inTag = 5'(10 + c);
      tick();
    end
    // Offer an extra request while stalled; it must not be taken.
    inA = 32'd1; inB = 32'd2; inSigned = 1'b0; inTag = 5'd31;
    for (int h = 0; h < 5; h++) begin
      testsRun++; if (inReady !== 1'b0) begin testsFailed++; $display("[TB] FAIL bp_in_ready hold %0d got %b want 0", h, inReady); end
      testsRun++; if (outValid !== 1'b1 || outTag !== 5'd10) begin testsFailed++; $display("[TB] FAIL bp_hold %0d valid %b tag %0d want 1 tag 10", h, outValid, outTag); end
      testsRun++; if ({outEq, outGt, outLt} !== 3'b100) begin testsFailed++; $display("[TB] FAIL bp_hold_flags %0d got %b want 100", h, {outEq, outGt, outLt}); end
      tick();
    end
    inValid = 1'b0;
    outReady = 1'b1;
    #1;
    testsRun++; if (inReady !== 1'b1) begin testsFailed++; $display("[TB] FAIL bp_release_in_ready got %b want 1", inReady); end
    for (int j = 0; j < 4; j++) begin
      testsRun++; if (outValid !== 1'b1 || outTag !== 5'(10 + j)) begin testsFailed++; $display("[TB] FAIL bp_drain %0d valid %b tag %0d want 1 tag %0d", j, outValid, outTag, 10 + j); end
      testsRun++; if ({outEq, outGt, outLt} !== ve[j]) begin testsFailed++; $display("[TB] FAIL bp_drain_flags %0d got %b want %b", j, {outEq, outGt, outLt}, ve[j]); end
      tick();
    end
    for (int e = 0; e < 3; e++) begin
      testsRun++; if (outValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL bp_extra_result %0d tag %0d", e, outTag); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic [2:0] fl; logic [4:0] tg;
    outReady = 1'b1;
    inValid = 1'b1; inA = 32'd9; inB = 32'd1; inSigned = 1'b0; inTag = 5'd20;
    tick();
    inTag = 5'd21;
    tick();
    inTag = 5'd22; reset = 1'b1;
    tick();
    reset = 1'b0; inValid = 1'b0;
    for (int e = 0; e < 6; e++) begin
      testsRun++; if (outValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL rst_mid_stale %0d got valid %b tag %0d", e, outValid, outTag); end
      tick();
    end
    applyStimulus(32'h0000_000A, 32'h0000_000A, 1'b0, 5'd23, lat, fl, tg);
    testsRun++; if (lat != 4) begin testsFailed++; $display("[TB] FAIL rst_mid_latency got %0d want 4", lat); end
    testsRun++; if (fl !== 3'b100 || tg !== 5'd23) begin testsFailed++; $display("[TB] FAIL rst_mid_result flags %b tag %0d want 100 tag 23", fl, tg); end
  endtask

`ifdef PIPELINED_COMPARATOR_FLUSH_EN
  task automatic test_flush();
    int lat; logic [2:0] fl; logic [4:0] tg;
    outReady = 1'b1;
    for (int c = 0; c < 3; c++) begin
      inValid = 1'b1; inA = 32'd2; inB = 32'd2; inSigned = 1'b0; inTag = 5'(24 + c);
      tick();
    end
    inTag = 5'd27; flush = 1'b1;
    #1;
    testsRun++; if (inReady !== 1'b0) begin testsFailed++; $display("[TB] FAIL flush_in_ready got %b want 0", inReady); end
    tick();
    flush = 1'b0; inValid = 1'b0;
    testsRun++; if (outValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL flush_out_valid got %b want 0", outValid); end
    applyStimulus(32'd5, 32'd9, 1'b0, 5'd28, lat, fl, tg);
    testsRun++; if (lat != 4) begin testsFailed++; $display("[TB] FAIL flush_next_latency got %0d want 4", lat); end
    testsRun++; if (fl !== 3'b001 || tg !== 5'd28) begin testsFailed++; $display("[TB] FAIL flush_next_result flags %b tag %0d want 001 tag 28", fl, tg); end
  endtask
`endif

  task automatic test_width16();
    logic [15:0] va [2] = '{16'h1234, 16'hF000};
    logic [15:0] vb [2] = '{16'h1243, 16'h0FFF};
    logic        vs [2] = '{1'b0, 1'b1};
    int lat;
    outReady16 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      inValid16 = 1'b1; inA16 = va[i]; inB16 = vb[i]; inSigned16 = vs[i]; inTag16 = 5'(7 + i);
      tick();
      inValid16 = 1'b0;
      lat = 1;
      while (outValid16 !== 1'b1 && lat < 20) begin
        tick();
        lat++;
      end
      testsRun++; if (lat != 4) begin testsFailed++; $display("[TB] FAIL w16_latency[%0d] got %0d want 4", i, lat); end
      testsRun++; if ({outEq16, outGt16, outLt16} !== 3'b001) begin testsFailed++; $display("[TB] FAIL w16_flags[%0d] got %b want 001", i, {outEq16, outGt16, outLt16}); end
      testsRun++; if (outTag16 !== 5'(7 + i)) begin testsFailed++; $display("[TB] FAIL w16_tag[%0d] got %0d want %0d", i, outTag16, 7 + i); end
    end
  endtask

  // Scenario sequence.
  initial begin
    reset = 1'b1;
    inValid = 1'b0; inA = '0; inB = '0; inSigned = 1'b0; inTag = '0; outReady = 1'b1;
    inValid16 = 1'b0; inA16 = '0; inB16 = '0; inSigned16 = 1'b0; inTag16 = '0; outReady16 = 1'b1;
`ifdef PIPELINED_COMPARATOR_FLUSH_EN
    flush = 1'b0; flush16 = 1'b0;
`endif
    test_reset();
    test_unsigned();
    test_signed();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
`ifdef PIPELINED_COMPARATOR_FLUSH_EN
    test_flush();
`endif
    test_width16();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
